// File: rtl/bp_common_pkg.sv
// ----------------------------------------------------------------------------
//  bp_common_pkg
//  Shared types for the configuration bank and its switch sequencer.
//  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bp_common_pkg;

   typedef enum logic [1:0] {
      e_cfg_idle  = 2'd0,
      e_cfg_drain = 2'd1,
      e_cfg_apply = 2'd2
   } bp_cfg_bank_state_e;

endpackage

`default_nettype wire

// File: rtl/bp_cfg_bank_if.sv
// ----------------------------------------------------------------------------
//  bp_cfg_bank_if
//  Write, read, switch and active-configuration signals of bp_cfg_bank.
//  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bp_cfg_bank_if #(
   parameter int els_p   = 16,
   parameter int width_p = 64
) ();
   localparam int lg_els_lp = $clog2(els_p);

   logic                 w_v_i;
   logic                 w_ready_o;
   logic [lg_els_lp-1:0] w_addr_i;
   logic [width_p-1:0]   w_data_i;

   logic                 r_v_i;
   logic [lg_els_lp-1:0] r_addr_i;
   logic                 r_v_o;
   logic [width_p-1:0]   r_data_o;
   logic                 r_entry_v_o;

   logic                 switch_v_i;
   logic                 switch_ready_o;
   logic [lg_els_lp-1:0] switch_sel_i;
   logic                 quiesce_i;

   logic [lg_els_lp-1:0] active_sel_o;
   logic [width_p-1:0]   active_cfg_o;
   logic                 switch_done_o;
   logic                 switch_err_o;

   modport slave (
      input  w_v_i, w_addr_i, w_data_i, r_v_i, r_addr_i,
             switch_v_i, switch_sel_i, quiesce_i,
      output w_ready_o, r_v_o, r_data_o, r_entry_v_o, switch_ready_o,
             active_sel_o, active_cfg_o, switch_done_o, switch_err_o
   );

   modport master (
      output w_v_i, w_addr_i, w_data_i, r_v_i, r_addr_i,
             switch_v_i, switch_sel_i, quiesce_i,
      input  w_ready_o, r_v_o, r_data_o, r_entry_v_o, switch_ready_o,
             active_sel_o, active_cfg_o, switch_done_o, switch_err_o
   );

endinterface

`default_nettype wire

// File: rtl/bp_cfg_bank_switch_fsm.sv
// ----------------------------------------------------------------------------
//  bp_cfg_bank_switch_fsm
//  IDLE -> DRAIN -> APPLY sequencer for switching the active configuration.
//  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bp_cfg_bank_switch_fsm
   import bp_common_pkg::*;
#(
   parameter int lg_els_p = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                locked,
   input  logic                switch_v,
   input  logic [lg_els_p-1:0] switch_sel,
   input  logic                sel_valid,
   input  logic                quiesce,
   output logic                switch_ready,
   output logic                busy,
   output logic                apply,
   output logic [lg_els_p-1:0] target,
   output logic                switch_done,
   output logic                switch_err
);

   bp_cfg_bank_state_e  state, state_n;
   logic [lg_els_p-1:0] target_n;
   logic                done_n, err_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= e_cfg_idle;
         target      <= '0;
         switch_done <= 1'b0;
         switch_err  <= 1'b0;
      end else begin
         state       <= state_n;
         target      <= target_n;
         switch_done <= done_n;
         switch_err  <= err_n;
      end
   end

   always_comb begin
      state_n      = state;
      target_n     = target;
      done_n       = 1'b0;
      err_n        = 1'b0;
      switch_ready = (state == e_cfg_idle) && !locked;
      case (state)
         e_cfg_idle: begin
            if (switch_v && switch_ready) begin
               if (sel_valid) begin
                  target_n = switch_sel;
                  state_n  = e_cfg_drain;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         e_cfg_drain: begin
            if (quiesce) state_n = e_cfg_apply;
         end
         e_cfg_apply: begin
            state_n = e_cfg_idle;
            done_n  = 1'b1;
         end
         default: state_n = e_cfg_idle;
      endcase
   end

   assign busy  = (state != e_cfg_idle);
   assign apply = (state == e_cfg_apply);

endmodule

`default_nettype wire

// File: rtl/bp_cfg_bank.sv
// ----------------------------------------------------------------------------
//  bp_cfg_bank
//  Bank of configuration entries with a quiesce-gated active-config switch.
//  Optional feature macro: BP_CFG_BANK_LOCK_EN (adds sticky lock_i).
//  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bp_cfg_bank
   import bp_common_pkg::*;
#(
   parameter int                 els_p       = 16,
   parameter int                 width_p     = 64,
   parameter int unsigned        reset_sel_p = 0,
   parameter logic [width_p-1:0] reset_cfg_p = '0
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
`ifdef BP_CFG_BANK_LOCK_EN
   input  logic          lock_i,
`endif
   bp_cfg_bank_if.slave  cfg
);

   localparam int lg_els_lp = $clog2(els_p);

   logic [width_p-1:0]   entry_mem [els_p];
   logic [els_p-1:0]     valid;
   logic                 read_v;
   logic                 read_entry_v;
   logic [width_p-1:0]   read_data;
   logic [lg_els_lp-1:0] active_sel;
   logic [width_p-1:0]   active_cfg;

   logic                 locked;
   logic                 busy;
   logic                 apply;
   logic [lg_els_lp-1:0] target;
   logic                 write_ready;
   logic                 write_fire;

`ifdef BP_CFG_BANK_LOCK_EN
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)  locked <= 1'b0;
      else if (lock_i) locked <= 1'b1;
   end
`else
   assign locked = 1'b0;
`endif

   // The pending target is frozen while a switch is in flight.
   assign write_ready = !locked && !(busy && (cfg.w_addr_i == target));
   assign write_fire  = cfg.w_v_i && write_ready;

   bp_cfg_bank_switch_fsm #(
      .lg_els_p (lg_els_lp)
   ) switch_fsm (
      .clk          (clk_i),
      .reset_n      (reset_n_i),
      .locked       (locked),
      .switch_v     (cfg.switch_v_i),
      .switch_sel   (cfg.switch_sel_i),
      .sel_valid    (valid[cfg.switch_sel_i]),
      .quiesce      (cfg.quiesce_i),
      .switch_ready (cfg.switch_ready_o),
      .busy         (busy),
      .apply        (apply),
      .target       (target),
      .switch_done  (cfg.switch_done_o),
      .switch_err   (cfg.switch_err_o)
   );

   // Entry storage and read data carry no reset.
   always_ff @(posedge clk_i) begin
      if (write_fire) entry_mem[cfg.w_addr_i] <= cfg.w_data_i;
      if (cfg.r_v_i)  read_data <= entry_mem[cfg.r_addr_i];
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         valid        <= '0;
         read_v       <= 1'b0;
         read_entry_v <= 1'b0;
         active_sel   <= lg_els_lp'(reset_sel_p);
         active_cfg   <= reset_cfg_p;
      end else begin
         if (write_fire) valid[cfg.w_addr_i] <= 1'b1;
         read_v <= cfg.r_v_i;
         if (cfg.r_v_i) read_entry_v <= valid[cfg.r_addr_i];
         if (apply) begin
            active_sel <= target;
            active_cfg <= entry_mem[target];
         end
      end
   end

   assign cfg.w_ready_o    = write_ready;
   assign cfg.r_v_o        = read_v;
   assign cfg.r_data_o     = read_data;
   assign cfg.r_entry_v_o  = read_entry_v;
   assign cfg.active_sel_o = active_sel;
   assign cfg.active_cfg_o = active_cfg;

endmodule

`default_nettype wire

// File: tb/tb_bp_cfg_bank.sv
// ----------------------------------------------------------------------------
//  tb_bp_cfg_bank
//  Scoreboard bench for bp_cfg_bank against an array-based reference model.
//  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bp_cfg_bank;

   localparam logic [63:0] rst_cfg_lp = 64'hC0FF_EE00_0000_0001;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bp_cfg_bank_if #(.els_p(16), .width_p(64)) bus ();

`ifdef BP_CFG_BANK_LOCK_EN
   logic lock = 1'b0;
`endif

   bp_cfg_bank #(
      .els_p       (16),
      .width_p     (64),
      .reset_sel_p (0),
      .reset_cfg_p (rst_cfg_lp)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
`ifdef BP_CFG_BANK_LOCK_EN
      .lock_i    (lock),
`endif
      .cfg       (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   typedef struct { bit ev; bit known; logic [63:0] d; } rd_t;
   typedef struct { bit is_err; bit [3:0] sel; logic [63:0] cfg; } sw_t;
   rd_t rd_q[$];
   sw_t sw_q[$];

   logic [63:0] mem_m   [16];
   bit          valid_m [16];
   bit          known_m [16];
   bit [3:0]    act_sel_m = 4'd0;
   logic [63:0] act_cfg_m = rst_cfg_lp;
   bit          busy_m    = 1'b0;
   bit [3:0]    tgt_m     = 4'd0;
   bit          locked_m  = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: pops the scoreboard whenever the DUT presents a result.
   rd_t re;
   sw_t se;
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.r_v_o) begin
            if (rd_q.size() == 0) begin
               check("rd_unexpected_qsize", 64'(rd_q.size()), 64'd1);
            end else begin
               re = rd_q.pop_front();
               check("rd_entry_v", 64'(bus.r_entry_v_o), 64'(re.ev));
               if (re.known) check("rd_data", bus.r_data_o, re.d);
            end
         end
         if (bus.switch_done_o || bus.switch_err_o) begin
            check("done_err_overlap", 64'(bus.switch_done_o & bus.switch_err_o), 64'd0);
            if (sw_q.size() == 0) begin
               check("sw_unexpected_qsize", 64'(sw_q.size()), 64'd1);
            end else begin
               se = sw_q.pop_front();
               check("sw_err",     64'(bus.switch_err_o),  64'(se.is_err));
               check("sw_done",    64'(bus.switch_done_o), 64'(!se.is_err));
               check("active_sel", 64'(bus.active_sel_o),  64'(se.sel));
               check("active_cfg", bus.active_cfg_o,       se.cfg);
            end
         end
      end
   end

   task automatic cycle(bit wv, bit [3:0] wa, logic [63:0] wd, bit rv, bit [3:0] ra);
      bit exp_rdy;
      bus.w_v_i = wv; bus.w_addr_i = wa; bus.w_data_i = wd;
      bus.r_v_i = rv; bus.r_addr_i = ra;
      #1;
      exp_rdy = !locked_m && !(busy_m && (wa == tgt_m));
      if (wv) check("w_ready", 64'(bus.w_ready_o), 64'(exp_rdy));
      if (rv) rd_q.push_back(rd_t'{valid_m[ra], known_m[ra], mem_m[ra]});
      if (wv && exp_rdy) begin
         mem_m[wa] = wd; valid_m[wa] = 1'b1; known_m[wa] = 1'b1;
      end
      step();
      bus.w_v_i = 1'b0; bus.r_v_i = 1'b0;
   endtask

   task automatic any_cycle(bit rnd);
      if (rnd) cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     {$urandom, $urandom}, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      else     step();
   endtask

   task automatic wait_sw();
      for (int i = 0; i < 6 && sw_q.size() != 0; i++) step();
      check("sw_timeout_qsize", 64'(sw_q.size()), 64'd0);
   endtask

   task automatic sw_start(bit [3:0] sel, output bit ok);
      bus.switch_v_i = 1'b1; bus.switch_sel_i = sel;
      #1;
      check("switch_ready_idle", 64'(bus.switch_ready_o), 64'(!locked_m));
      ok = valid_m[sel];
      if (ok) begin
         sw_q.push_back(sw_t'{1'b0, sel, mem_m[sel]});
         busy_m = 1'b1; tgt_m = sel;
      end else begin
         sw_q.push_back(sw_t'{1'b1, act_sel_m, act_cfg_m});
      end
      step();
      bus.switch_v_i = 1'b0;
   endtask

   task automatic sw_hold(int n, bit rnd);
      for (int i = 0; i < n; i++) begin
         check("drain_ready", 64'(bus.switch_ready_o), 64'd0);
         check("drain_no_done", 64'(bus.switch_done_o), 64'd0);
         any_cycle(rnd);
      end
   endtask

   task automatic sw_finish(bit rnd);
      bus.quiesce_i = 1'b1;
      any_cycle(rnd);
      bus.quiesce_i = 1'b0;
      check("apply_sel_held", 64'(bus.active_sel_o), 64'(act_sel_m));
      any_cycle(rnd);
      busy_m = 1'b0;
      act_sel_m = tgt_m;
      act_cfg_m = mem_m[tgt_m];
      wait_sw();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      for (int i = 0; i < 16; i++) begin
         valid_m[i] = 1'b0; known_m[i] = 1'b0; mem_m[i] = '0;
      end
      bus.w_v_i = 0; bus.w_addr_i = '0; bus.w_data_i = '0;
      bus.r_v_i = 0; bus.r_addr_i = '0;
      bus.switch_v_i = 0; bus.switch_sel_i = '0; bus.quiesce_i = 0;
      repeat (3) step();
      reset_n = 1'b1;
      step();

      check("rst_r_v",          64'(bus.r_v_o),          64'd0);
      check("rst_done",         64'(bus.switch_done_o),  64'd0);
      check("rst_err",          64'(bus.switch_err_o),   64'd0);
      check("rst_active_sel",   64'(bus.active_sel_o),   64'd0);
      check("rst_active_cfg",   bus.active_cfg_o,        rst_cfg_lp);
      check("rst_switch_ready", 64'(bus.switch_ready_o), 64'd1);
      check("rst_w_ready",      64'(bus.w_ready_o),      64'd1);

      cycle(1, 4'd3, 64'hDEAD_BEEF, 0, 4'd0);
      cycle(0, 4'd0, '0, 1, 4'd3);
      cycle(0, 4'd0, '0, 1, 4'd4);

      sw_start(4'd5, ok);
      wait_sw();
      check("err_keeps_sel", 64'(bus.active_sel_o), 64'd0);
      check("err_keeps_cfg", bus.active_cfg_o, rst_cfg_lp);

      cycle(1, 4'd2, 64'h1234, 0, 4'd0);
      sw_start(4'd2, ok);
      sw_hold(10, 1'b0);
      cycle(1, 4'd2, 64'h0BAD, 0, 4'd0);
      cycle(1, 4'd7, 64'h7777_0007, 0, 4'd0);
      sw_finish(1'b0);
      cycle(0, 4'd0, '0, 1, 4'd2);
      cycle(0, 4'd0, '0, 1, 4'd7);

      cycle(1, 4'd2, 64'h5678, 0, 4'd0);
      check("active_write_no_effect", bus.active_cfg_o, 64'h1234);
      sw_start(4'd2, ok);
      sw_hold(1, 1'b0);
      sw_finish(1'b0);

      for (int it = 0; it < 200; it++) begin
         if ($urandom_range(0, 7) == 0) begin
            sw_start(4'($urandom_range(0, 15)), ok);
            if (ok) begin
               sw_hold(int'($urandom_range(0, 4)), 1'b1);
               sw_finish(1'b1);
            end else begin
               wait_sw();
            end
         end else begin
            any_cycle(1'b1);
         end
      end

      // Abort a switch while it sits in APPLY.
      cycle(1, 4'd7, 64'hABCD_0007, 0, 4'd0);
      sw_start(4'd7, ok);
      bus.quiesce_i = 1'b1;
      step();
      bus.quiesce_i = 1'b0;
      sw_q.delete();
      busy_m = 1'b0;
      reset_n = 1'b0;
      #1;
      check("arst_active_sel", 64'(bus.active_sel_o), 64'd0);
      check("arst_active_cfg", bus.active_cfg_o, rst_cfg_lp);
      check("arst_done",       64'(bus.switch_done_o), 64'd0);
      check("arst_err",        64'(bus.switch_err_o), 64'd0);
      check("arst_r_v",        64'(bus.r_v_o), 64'd0);
      repeat (2) step();
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) valid_m[i] = 1'b0;
      act_sel_m = 4'd0; act_cfg_m = rst_cfg_lp;
      repeat (4) step();
      check("post_rst_ready",      64'(bus.switch_ready_o), 64'd1);
      check("post_rst_active_cfg", bus.active_cfg_o, rst_cfg_lp);
      cycle(0, 4'd0, '0, 1, 4'd7);
      cycle(0, 4'd0, '0, 1, 4'd2);
      sw_start(4'd7, ok);
      wait_sw();

`ifdef BP_CFG_BANK_LOCK_EN
      lock = 1'b1;
      step();
      lock = 1'b0;
      locked_m = 1'b1;
      repeat (3) begin
         check("lock_w_ready",      64'(bus.w_ready_o),      64'd0);
         check("lock_switch_ready", 64'(bus.switch_ready_o), 64'd0);
         step();
      end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      locked_m = 1'b0;
      for (int i = 0; i < 16; i++) valid_m[i] = 1'b0;
      step();
      check("unlock_w_ready",      64'(bus.w_ready_o),      64'd1);
      check("unlock_switch_ready", 64'(bus.switch_ready_o), 64'd1);
`endif

      for (int i = 0; i < 6 && rd_q.size() != 0; i++) step();
      check("rd_timeout_qsize", 64'(rd_q.size()), 64'd0);
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
